// File: rtl/hazard_stall_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_stall_if                                               |
// | Purpose  : Bundles the hazard-controller signals: decode operand         |
// |            fields, EX load info, MEM branch and dmem busy status (into   |
// |            the controller), plus the pipeline enables, flushes and perf  |
// |            counters (out of the controller).                             |
// | Modports : slave  - hazard_stall_ctrl side                               |
// |            master - pipeline / environment side                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface hazard_stall_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_branch_taken;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           mem_branch_taken, dmem_busy,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, pipe_hold, stall_count, flush_count
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           mem_branch_taken, dmem_busy,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, pipe_hold, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_stall_ctrl                                             |
// | Purpose  : Hazard controller for the 5-stage RV64 pipeline. Inserts      |
// |            load-use bubbles (LOAD_USE_BUBBLES per hazard), flushes       |
// |            IF/ID, ID/EX and EX/MEM on a taken branch resolved in MEM and |
// |            freezes the pipe while data memory is busy. All responses are |
// |            Mealy: same-cycle from state plus current inputs.             |
// | Ports    : clk   - core clock, rising edge                               |
// |            reset - synchronous, active-high                              |
// |            bus   - hazard_stall_if.slave (hazard inputs, enables,        |
// |                    flushes, stall_count / flush_count)                   |
// | Options  : HAZARD_PERF_CNT_EN - when defined, saturating stall and flush |
// |            counters are built; otherwise both counts read as zero.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_stall_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  hazard_stall_if.slave bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Bubbles still owed after the one issued in the hazard-detect cycle.
  localparam logic [3:0] BUB_RELOAD = 4'(LOAD_USE_BUBBLES - 1);

  state_e     state_q, state_d;
  logic [3:0] bub_cnt_q, bub_cnt_d;
  logic       load_use_hit;

  // x0 is never a real dependency, so ex_rd == 0 cannot hazard.
  assign load_use_hit = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      bub_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bub_cnt_d        = bub_cnt_q;
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.idex_bubble  = 1'b0;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.exmem_flush  = 1'b0;
    bus.pipe_hold    = 1'b0;

    if (reset || bus.dmem_busy) begin
      // Freeze: nothing moves, state holds. Branch/hit are picked up once
      // busy drops since their sources are held upstream.
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.pipe_hold  = 1'b1;
    end else if (bus.mem_branch_taken) begin
      // The hazarding ID instruction is flushed, so any stall is moot.
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
      state_d         = RUN;
      bub_cnt_d       = 4'd0;
    end else if (state_q == STALL) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      bub_cnt_d       = bub_cnt_q - 4'd1;
      if (bub_cnt_q == 4'd1) begin
        state_d = RUN;
      end
    end else if (load_use_hit) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        state_d   = STALL;
        bub_cnt_d = BUB_RELOAD;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Count off the outputs themselves so a counter only moves when its
  // event is actually driven; saturate at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (bus.idex_bubble && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (bus.ifid_flush && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= {CNT_W{1'b0}};
      flush_count_q <= {CNT_W{1'b0}};
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
  assign bus.flush_count = flush_count_q;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
  assign bus.flush_count = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hazard_stall_ctrl                                          |
// | Purpose  : Directed self-checking bench for hazard_stall_ctrl. Three     |
// |            instances share stimulus: LOAD_USE_BUBBLES=1, =3, and a       |
// |            CNT_W=2 instance for counter saturation.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector: {pc_write, ifid_write, idex_bubble, ifid_flush,
  //                 idex_flush, exmem_flush, pipe_hold}
  localparam logic [6:0] DEF  = 7'b1100000;
  localparam logic [6:0] HOLD = 7'b0000001;
  localparam logic [6:0] BUB  = 7'b0010000;
  localparam logic [6:0] FLU  = 7'b1101110;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] s_rs1, s_rs2, s_rd;
  logic       s_u1, s_u2, s_mr, s_br, s_busy;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_stall_if #(.CNT_W(16)) if1 ();
  hazard_stall_if #(.CNT_W(16)) if3 ();
  hazard_stall_if #(.CNT_W(2))  ifs ();

  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(16)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(2))  duts (.clk(clk), .reset(reset), .bus(ifs));

  assign if1.id_rs1 = s_rs1;  assign if3.id_rs1 = s_rs1;  assign ifs.id_rs1 = s_rs1;
  assign if1.id_rs2 = s_rs2;  assign if3.id_rs2 = s_rs2;  assign ifs.id_rs2 = s_rs2;
  assign if1.id_use_rs1 = s_u1;  assign if3.id_use_rs1 = s_u1;  assign ifs.id_use_rs1 = s_u1;
  assign if1.id_use_rs2 = s_u2;  assign if3.id_use_rs2 = s_u2;  assign ifs.id_use_rs2 = s_u2;
  assign if1.ex_mem_read = s_mr; assign if3.ex_mem_read = s_mr; assign ifs.ex_mem_read = s_mr;
  assign if1.ex_rd = s_rd;  assign if3.ex_rd = s_rd;  assign ifs.ex_rd = s_rd;
  assign if1.mem_branch_taken = s_br; assign if3.mem_branch_taken = s_br; assign ifs.mem_branch_taken = s_br;
  assign if1.dmem_busy = s_busy; assign if3.dmem_busy = s_busy; assign ifs.dmem_busy = s_busy;

  logic [6:0] o1, o3, os;
  assign o1 = {if1.pc_write, if1.ifid_write, if1.idex_bubble, if1.ifid_flush,
               if1.idex_flush, if1.exmem_flush, if1.pipe_hold};
  assign o3 = {if3.pc_write, if3.ifid_write, if3.idex_bubble, if3.ifid_flush,
               if3.idex_flush, if3.exmem_flush, if3.pipe_hold};
  assign os = {ifs.pc_write, ifs.ifid_write, ifs.idex_bubble, ifs.ifid_flush,
               ifs.idex_flush, ifs.exmem_flush, ifs.pipe_hold};

  // Stimulus helpers (drive only, no checking).
  task automatic clear_in();
    s_rs1 = 5'd0; s_rs2 = 5'd0; s_rd = 5'd0;
    s_u1 = 1'b0; s_u2 = 1'b0; s_mr = 1'b0; s_br = 1'b0; s_busy = 1'b0;
  endtask

  task automatic set_hit_rs2(input logic [4:0] rd);
    clear_in();
    s_mr = 1'b1; s_rd = rd; s_rs2 = 5'd5; s_u2 = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_hit_rs2(5'd5);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (o1 !== HOLD) begin n_bad++; $display("FAIL reset_out1[%0d]: got %b want %b", i, o1, HOLD); end
      n_cmp++;
      if (o3 !== HOLD) begin n_bad++; $display("FAIL reset_out3[%0d]: got %b want %b", i, o3, HOLD); end
      next_cycle();
    end
    reset = 1'b0;
    clear_in();
    #1;
    n_cmp++;
    if (o3 !== DEF) begin n_bad++; $display("FAIL reset_release_out: got %b want %b", o3, DEF); end
    n_cmp++;
    if (if1.stall_count !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", if1.stall_count); end
    n_cmp++;
    if (if1.flush_count !== 16'd0) begin n_bad++; $display("FAIL reset_flush_cnt: got %0d want 0", if1.flush_count); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_hit_rs2(5'd5);
    #1;
    n_cmp++;
    if (o1 !== BUB) begin n_bad++; $display("FAIL lu_hit_out: got %b want %b", o1, BUB); end
    next_cycle();
    clear_in();
    #1;
    n_cmp++;
    if (o1 !== DEF) begin n_bad++; $display("FAIL lu_after_out: got %b want %b", o1, DEF); end
    n_cmp++;
    if (if1.stall_count !== (PERF ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d want %0d", if1.stall_count, PERF ? 1 : 0); end
    next_cycle();
    // ex_rd == x0 never hazards, even with a matching source field
    set_hit_rs2(5'd0);
    s_rs2 = 5'd0;
    #1;
    n_cmp++;
    if (o1 !== DEF) begin n_bad++; $display("FAIL lu_x0_out: got %b want %b", o1, DEF); end
    next_cycle();
    // rs1 path hazard
    clear_in();
    s_mr = 1'b1; s_rd = 5'd7; s_rs1 = 5'd7; s_u1 = 1'b1;
    #1;
    n_cmp++;
    if (o1 !== BUB) begin n_bad++; $display("FAIL lu_rs1_out: got %b want %b", o1, BUB); end
    next_cycle();
    // matching rs1 field but not read -> no hazard
    s_u1 = 1'b0;
    #1;
    n_cmp++;
    if (o1 !== DEF) begin n_bad++; $display("FAIL lu_rs1_unused_out: got %b want %b", o1, DEF); end
    next_cycle();
    // matching register but not a load -> no hazard
    set_hit_rs2(5'd5);
    s_mr = 1'b0;
    #1;
    n_cmp++;
    if (o1 !== DEF) begin n_bad++; $display("FAIL lu_noload_out: got %b want %b", o1, DEF); end
    next_cycle();
    clear_in();
    #1;
    n_cmp++;
    if (if1.stall_count !== (PERF ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL lu_stall_cnt2: got %0d want %0d", if1.stall_count, PERF ? 2 : 0); end
  endtask

  task automatic test_multi_bubble();
    logic [6:0] exp_seq [4];
    exp_seq[0] = BUB; exp_seq[1] = BUB; exp_seq[2] = BUB; exp_seq[3] = DEF;
    do_reset();
    set_hit_rs2(5'd5);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (o3 !== exp_seq[i]) begin n_bad++; $display("FAIL mb_out[%0d]: got %b want %b", i, o3, exp_seq[i]); end
      next_cycle();
      clear_in();
    end
    #1;
    n_cmp++;
    if (if3.stall_count !== (PERF ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL mb_stall_cnt: got %0d want %0d", if3.stall_count, PERF ? 3 : 0); end
  endtask

  task automatic test_branch_abort();
    do_reset();
    set_hit_rs2(5'd5);
    #1;
    n_cmp++;
    if (o3 !== BUB) begin n_bad++; $display("FAIL ba_hit_out: got %b want %b", o3, BUB); end
    next_cycle();
    clear_in();
    s_br = 1'b1;
    #1;
    n_cmp++;
    if (o3 !== FLU) begin n_bad++; $display("FAIL ba_flush_out: got %b want %b", o3, FLU); end
    next_cycle();
    clear_in();
    #1;
    n_cmp++;
    if (o3 !== DEF) begin n_bad++; $display("FAIL ba_after_out: got %b want %b", o3, DEF); end
    n_cmp++;
    if (if3.flush_count !== (PERF ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL ba_flush_cnt: got %0d want %0d", if3.flush_count, PERF ? 1 : 0); end
    n_cmp++;
    if (if3.stall_count !== (PERF ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL ba_stall_cnt: got %0d want %0d", if3.stall_count, PERF ? 1 : 0); end
    next_cycle();
  endtask

  task automatic test_busy_freeze();
    do_reset();
    set_hit_rs2(5'd5);
    #1;
    n_cmp++;
    if (o3 !== BUB) begin n_bad++; $display("FAIL bf_hit_out: got %b want %b", o3, BUB); end
    next_cycle();
    clear_in();
    s_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (o3 !== HOLD) begin n_bad++; $display("FAIL bf_busy_out[%0d]: got %b want %b", i, o3, HOLD); end
      next_cycle();
    end
    s_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (o3 !== ((i < 2) ? BUB : DEF)) begin n_bad++; $display("FAIL bf_resume_out[%0d]: got %b want %b", i, o3, (i < 2) ? BUB : DEF); end
      next_cycle();
    end
    #1;
    n_cmp++;
    if (if3.stall_count !== (PERF ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL bf_stall_cnt: got %0d want %0d", if3.stall_count, PERF ? 3 : 0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Hit held for three cycles with single-bubble config: bubble each cycle
    set_hit_rs2(5'd5);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (o1 !== BUB) begin n_bad++; $display("FAIL b2b_hit_out[%0d]: got %b want %b", i, o1, BUB); end
      next_cycle();
    end
    // Branch and hit together: branch wins, no bubble
    s_br = 1'b1;
    #1;
    n_cmp++;
    if (o1 !== FLU) begin n_bad++; $display("FAIL b2b_br_hit_out: got %b want %b", o1, FLU); end
    next_cycle();
    // Busy masks a pending branch; branch acts once busy drops
    s_busy = 1'b1;
    #1;
    n_cmp++;
    if (o1 !== HOLD) begin n_bad++; $display("FAIL b2b_busy_br_out: got %b want %b", o1, HOLD); end
    next_cycle();
    s_busy = 1'b0;
    #1;
    n_cmp++;
    if (o1 !== FLU) begin n_bad++; $display("FAIL b2b_br_after_busy: got %b want %b", o1, FLU); end
    next_cycle();
    clear_in();
    #1;
    n_cmp++;
    if (if1.stall_count !== (PERF ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL b2b_stall_cnt: got %0d want %0d", if1.stall_count, PERF ? 3 : 0); end
    n_cmp++;
    if (if1.flush_count !== (PERF ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL b2b_flush_cnt: got %0d want %0d", if1.flush_count, PERF ? 2 : 0); end
  endtask

  task automatic test_saturation();
    do_reset();
    clear_in();
    s_br = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (os !== FLU) begin n_bad++; $display("FAIL sat_out[%0d]: got %b want %b", i, os, FLU); end
      next_cycle();
      if (i == 1) begin
        #1;
        n_cmp++;
        if (ifs.flush_count !== (PERF ? 2'd2 : 2'd0)) begin n_bad++; $display("FAIL sat_mid_cnt: got %0d want %0d", ifs.flush_count, PERF ? 2 : 0); end
      end
    end
    clear_in();
    #1;
    n_cmp++;
    if (ifs.flush_count !== (PERF ? 2'd3 : 2'd0)) begin n_bad++; $display("FAIL sat_flush_cnt: got %0d want %0d", ifs.flush_count, PERF ? 3 : 0); end
    n_cmp++;
    if (ifs.stall_count !== 2'd0) begin n_bad++; $display("FAIL sat_stall_cnt: got %0d want 0", ifs.stall_count); end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_load_use();
    test_multi_bubble();
    test_branch_abort();
    test_busy_freeze();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV64 core.
- Sequences PC/IF-ID write enables, ID/EX bubble insertion and branch flushes around the decode stage, where the immediate generator, register file and control unit operate.
- Handles load-use stalls (configurable bubble count), taken-branch flushes resolved in MEM, and data-memory busy freezes.
- Optionally keeps saturating performance counters.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal 1..15.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  core clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- id_rs1  input  5  rs1 field of the instruction in ID
- id_rs2  input  5  rs2 field of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_mem_read  input  1  EX-stage instruction is a load
- ex_rd  input  5  EX-stage destination register
- mem_branch_taken  input  1  branch in MEM resolved taken; PC mux selects target this cycle
- dmem_busy  input  1  data memory not ready; whole pipeline must hold
- pc_write  output  1  PC register update enable
- ifid_write  output  1  IF/ID register update enable
- idex_bubble  output  1  zero ID/EX control fields this cycle
- ifid_flush  output  1  clear IF/ID to NOP
- idex_flush  output  1  clear ID/EX to NOP
- exmem_flush  output  1  clear EX/MEM to NOP
- pipe_hold  output  1  hold all pipeline registers (ID/EX, EX/MEM, MEM/WB)
- stall_count  output  CNT_W  load-use bubble cycles inserted
- flush_count  output  CNT_W  taken-branch flush events

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Outputs are Mealy: combinational from registered state plus current inputs. No cycle of latency from hazard to response.
- hit = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Registered state: fsm (RUN, STALL), bub_cnt[3:0], stall_count, flush_count.
- Reset: fsm = RUN, bub_cnt = 0, counters = 0.
- While reset is high: pc_write = 0, ifid_write = 0, pipe_hold = 1, all flush outputs and idex_bubble = 0.
- Default outputs (no event): pc_write = 1, ifid_write = 1, all others 0.
- Priority, highest first: reset > dmem_busy > mem_branch_taken > STALL hold > hit.

dmem_busy:
- pc_write = 0, ifid_write = 0, pipe_hold = 1; no flush, no bubble.
- fsm, bub_cnt and counters hold.
- A branch or hit present in the same cycle is evaluated in the first cycle busy drops.

mem_branch_taken (not busy, either state):
- ifid_flush = idex_flush = exmem_flush = 1, pc_write = 1, ifid_write = 1, idex_bubble = 0.
- Next state RUN, bub_cnt = 0, flush_count + 1.
- Aborts any stall in progress; a simultaneous hit is ignored because the hazarding ID instruction is flushed.

RUN with hit:
- pc_write = 0, ifid_write = 0, idex_bubble = 1, stall_count + 1.
- If LOAD_USE_BUBBLES > 1: go to STALL, bub_cnt = LOAD_USE_BUBBLES - 1. Otherwise stay in RUN.

STALL:
- pc_write = 0, ifid_write = 0, idex_bubble = 1, stall_count + 1, bub_cnt - 1.
- When bub_cnt == 1, next state is RUN.
- hit is not re-evaluated while in STALL.

Counters:
- Saturate at all-ones; no wrap.
- They increment only in cycles where the corresponding output actually asserts.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_count and flush_count are implemented as described.
- Undefined: no counter registers; stall_count and flush_count are tied to 0. All other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with hit = 1 -> pc_write = 0, ifid_write = 0, pipe_hold = 1, idex_bubble = 0. After release: fsm RUN, counters 0.
- Load-use: LOAD_USE_BUBBLES = 1, ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 for one cycle -> exactly 1 cycle of pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_count = 1. Same stimulus with ex_rd = 0 -> no stall.
- Multi-bubble: LOAD_USE_BUBBLES = 3, single hit cycle -> 3 consecutive bubble cycles, then pc_write = 1; stall_count = 3.
- Branch aborts stall: LOAD_USE_BUBBLES = 3, hit, then mem_branch_taken in the 2nd bubble cycle -> that cycle shows all three flushes = 1, pc_write = 1, idex_bubble = 0; next cycle RUN with default outputs; flush_count = 1, stall_count = 1.
- Busy freeze: dmem_busy = 1 for 4 cycles during STALL with bub_cnt = 2 -> pipe_hold = 1, no bubble, bub_cnt unchanged. Remaining 2 bubbles follow after busy drops.
- Saturation: CNT_W = 2, 5 branch flushes -> flush_count = 3. With HAZARD_PERF_CNT_EN undefined -> both counts stay 0.
